// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

    // Fetch FSM: no request, request with data kept, request with data discarded.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // Byte distance between consecutive sequential instructions.
    localparam logic [31:0] INST_STEP = 32'd4;

    // One queued instruction together with its byte address.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush, push, pop and occupancy count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  push_entry_i,
    input  logic          pop_i,
    output fetch_entry_t  head_o,
    output logic          valid_o,
    output logic [CW-1:0] count_o
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    fetch_entry_t mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;

    // Pointer update; flush wins over push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; cleared on reset so the head reads zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_i && !flush_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_entry_i;
        end
    end

    assign count_o = wr_ptr_q - rd_ptr_q;
    assign valid_o = (count_o != '0);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch unit: issues sequential fetches and buffers the returned
// words in a small queue; branch redirects flush the queue and retarget fetch.
module instruction_fetch_queue
    import fetch_pkg::*;
#(
    parameter  int unsigned DEPTH    = 4,
    parameter  logic [31:0] RESET_PC = 32'h0000_0000,
    localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          imem_req,
    output logic [31:0]   imem_addr,
    input  logic          imem_ack,
    input  logic [31:0]   imem_rdata,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic          inst_valid,
    output logic [31:0]   inst_data,
    output logic [31:0]   inst_pc,
    input  logic          inst_ready,
    output logic [CW-1:0] occupancy
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  drain_addr_q, drain_addr_d;

    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_flush;
    fetch_entry_t push_entry;
    fetch_entry_t head;

    assign fifo_flush = redirect_valid;
    assign fifo_pop   = inst_valid && inst_ready && !redirect_valid;
    assign push_entry = '{pc: fetch_pc_q, inst: imem_rdata};

    // Next-state logic; redirect takes priority over ack, push and pop.
    // In DRAIN, fetch_pc already holds the redirect target while the
    // abandoned address is presented from drain_addr until its ack.
    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        drain_addr_d = drain_addr_q;
        fifo_push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = REQ;
                end else if (occupancy < FULL_CNT) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                    if (imem_ack) begin
                        state_d = REQ;
                    end else begin
                        drain_addr_d = fetch_pc_q;
                        state_d      = DRAIN;
                    end
                end else if (imem_ack) begin
                    fifo_push  = 1'b1;
                    fetch_pc_d = fetch_pc_q + INST_STEP;
                    // Post-push occupancy is occupancy + 1 - pop.
                    state_d    = (fifo_pop || (occupancy < LAST_CNT)) ? REQ : IDLE;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc;
                end
                if (imem_ack) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and address registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            fetch_pc_q   <= RESET_PC;
            drain_addr_q <= RESET_PC;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    assign imem_req  = (state_q != IDLE);
    assign imem_addr = (state_q == DRAIN) ? drain_addr_q : fetch_pc_q;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk),
        .rst_ni       (rst),
        .flush_i      (fifo_flush),
        .push_i       (fifo_push),
        .push_entry_i (push_entry),
        .pop_i        (fifo_pop),
        .head_o       (head),
        .valid_o      (inst_valid),
        .count_o      (occupancy)
    );

    assign inst_pc   = head.pc;
    assign inst_data = head.inst;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench for instruction_fetch_queue with a queue-based scoreboard.
module tb_instruction_fetch_queue;
    import fetch_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int unsigned CW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          inst_valid;
    logic [31:0]   inst_data;
    logic [31:0]   inst_pc;
    logic          inst_ready;
    logic [CW-1:0] occupancy;

    int           n_tests = 0;
    int           n_fail  = 0;
    fetch_entry_t sb[$];
    logic [31:0]  exp_pc;

    instruction_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'd2654435761) ^ 32'hC0DE_0000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic [31:0] data, input logic ready,
                         input logic redir, input logic [31:0] rpc);
        imem_ack       = ack;
        imem_rdata     = data;
        inst_ready     = ready;
        redirect_valid = redir;
        redirect_pc    = rpc;
    endtask

    // Ack the current fetch with the memory word for exp_pc and record it.
    task automatic ack_fetch(input logic ready);
        drive(1'b1, mem_word(exp_pc), ready, 1'b0, 32'h0);
        sb.push_back('{pc: exp_pc, inst: mem_word(exp_pc)});
        exp_pc = exp_pc + 32'd4;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        sb.delete();
        step();
        step();
        rst = 1'b1;
        step();
        exp_pc = RESET_PC;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step();
        step();
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_tests++; if (imem_addr !== RESET_PC) begin n_fail++; $display("FAIL reset_addr: got %h want %h", imem_addr, RESET_PC); end
        n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        n_tests++; if (occupancy !== '0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        n_tests++; if ({inst_pc, inst_data} !== 64'h0) begin n_fail++; $display("FAIL reset_head: got %h_%h want 0_0", inst_pc, inst_data); end
        rst = 1'b1;
        step();
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin n_fail++; $display("FAIL reset_first_fetch: got %b/%h want 1/%h", imem_req, imem_addr, RESET_PC); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            n_tests++; if ({imem_req, imem_addr} !== {1'b1, exp_pc}) begin n_fail++; $display("FAIL stream_req: got %b/%h want 1/%h", imem_req, imem_addr, exp_pc); end
            n_tests++; if (occupancy !== CW'(sb.size()) || occupancy > 1) begin n_fail++; $display("FAIL stream_occ: got %0d want %0d", occupancy, sb.size()); end
            n_tests++; if (inst_valid !== (sb.size() != 0)) begin n_fail++; $display("FAIL stream_valid: got %b want %b", inst_valid, sb.size() != 0); end
            if (sb.size() > 0) begin
                n_tests++; if ({inst_pc, inst_data} !== sb[0] || inst_pc !== exp_pc - 32'd4) begin n_fail++; $display("FAIL stream_head: got %h_%h want %h", inst_pc, inst_data, sb[0]); end
                void'(sb.pop_front());
            end
            ack_fetch(1'b1);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            n_tests++; if ({imem_req, imem_addr} !== {1'b1, exp_pc}) begin n_fail++; $display("FAIL full_req: got %b/%h want 1/%h", imem_req, imem_addr, exp_pc); end
            n_tests++; if (occupancy !== CW'(i)) begin n_fail++; $display("FAIL full_occ: got %0d want %0d", occupancy, i); end
            ack_fetch(1'b0);
            step();
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL full_idle: got %b want 0", imem_req); end
        n_tests++; if (occupancy !== CW'(DEPTH)) begin n_fail++; $display("FAIL full_occ4: got %0d want %0d", occupancy, DEPTH); end
        n_tests++; if ({inst_pc, inst_data} !== sb[0]) begin n_fail++; $display("FAIL full_head0: got %h_%h want %h", inst_pc, inst_data, sb[0]); end
        void'(sb.pop_front());
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_tests++; if (imem_req !== 1'b0 || occupancy !== CW'(3)) begin n_fail++; $display("FAIL full_after_pop: got req %b occ %0d want 0/3", imem_req, occupancy); end
        step();
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin n_fail++; $display("FAIL full_rearm: got %b/%h want 1/00000010", imem_req, imem_addr); end
        drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            n_tests++; if (inst_valid !== 1'b1 || {inst_pc, inst_data} !== sb[0]) begin n_fail++; $display("FAIL full_order: got %b %h_%h want %h", inst_valid, inst_pc, inst_data, sb[0]); end
            void'(sb.pop_front());
            step();
        end
        n_tests++; if (inst_valid !== 1'b0 || occupancy !== '0) begin n_fail++; $display("FAIL full_drained: got %b/%0d want 0/0", inst_valid, occupancy); end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_delayed_ack();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            n_tests++; if ({imem_req, imem_addr} !== {1'b1, exp_pc}) begin n_fail++; $display("FAIL delay_stable: got %b/%h want 1/%h", imem_req, imem_addr, exp_pc); end
            n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL delay_early: got %b want 0", inst_valid); end
            if (i == 3) ack_fetch(1'b0);
            else drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_tests++; if (inst_valid !== 1'b1 || {inst_pc, inst_data} !== sb[0]) begin n_fail++; $display("FAIL delay_entry: got %b %h_%h want %h", inst_valid, inst_pc, inst_data, sb[0]); end
        n_tests++; if (imem_addr !== exp_pc) begin n_fail++; $display("FAIL delay_next: got %h want %h", imem_addr, exp_pc); end
    endtask

    task automatic test_redirect_drain();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            ack_fetch(1'b0);
            step();
        end
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin n_fail++; $display("FAIL drain_pre: got %b/%h want 1/00000008", imem_req, imem_addr); end
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
        sb.delete();
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_tests++; if (occupancy !== '0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL drain_flush: got occ %0d valid %b want 0/0", occupancy, inst_valid); end
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin n_fail++; $display("FAIL drain_hold: got %b/%h want 1/00000008", imem_req, imem_addr); end
        step();
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin n_fail++; $display("FAIL drain_hold2: got %b/%h want 1/00000008", imem_req, imem_addr); end
        drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_tests++; if (occupancy !== '0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL drain_discard: got occ %0d valid %b want 0/0", occupancy, inst_valid); end
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h100}) begin n_fail++; $display("FAIL drain_target: got %b/%h want 1/00000100", imem_req, imem_addr); end
        exp_pc = 32'h100;
        ack_fetch(1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_tests++; if (inst_valid !== 1'b1 || {inst_pc, inst_data} !== sb[0]) begin n_fail++; $display("FAIL drain_entry: got %b %h_%h want %h", inst_valid, inst_pc, inst_data, sb[0]); end
    endtask

    task automatic test_redirect_collide();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ack_fetch(1'b0);
            step();
        end
        n_tests++; if (occupancy !== CW'(3) || imem_addr !== 32'hC) begin n_fail++; $display("FAIL collide_pre: got occ %0d addr %h want 3/0000000c", occupancy, imem_addr); end
        drive(1'b1, mem_word(32'hC), 1'b1, 1'b1, 32'h300);
        sb.delete();
        step();
        n_tests++; if (occupancy !== '0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL collide_flush: got occ %0d valid %b want 0/0", occupancy, inst_valid); end
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h300}) begin n_fail++; $display("FAIL collide_req: got %b/%h want 1/00000300", imem_req, imem_addr); end
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h180);
        step();
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h300}) begin n_fail++; $display("FAIL collide_drain: got %b/%h want 1/00000300", imem_req, imem_addr); end
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h200);
        step();
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, 32'h300}) begin n_fail++; $display("FAIL collide_drain2: got %b/%h want 1/00000300", imem_req, imem_addr); end
        drive(1'b1, 32'hBAD0_0BAD, 1'b0, 1'b0, 32'h0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_tests++; if ({imem_req, imem_addr, occupancy} !== {1'b1, 32'h200, CW'(0)}) begin n_fail++; $display("FAIL collide_target: got %b/%h/%0d want 1/00000200/0", imem_req, imem_addr, occupancy); end
        exp_pc = 32'h200;
        ack_fetch(1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_tests++; if (inst_valid !== 1'b1 || {inst_pc, inst_data} !== sb[0]) begin n_fail++; $display("FAIL collide_entry: got %b %h_%h want %h", inst_valid, inst_pc, inst_data, sb[0]); end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1'b1, mem_word(32'h0), 1'b1, 1'b1, 32'hFFFF_FFF8);
        step();
        n_tests++; if (occupancy !== '0 || imem_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL wrap_redirect: got occ %0d addr %h want 0/fffffff8", occupancy, imem_addr); end
        exp_pc = 32'hFFFF_FFF8;
        for (int i = 0; i < 4; i++) begin
            n_tests++; if ({imem_req, imem_addr} !== {1'b1, exp_pc}) begin n_fail++; $display("FAIL wrap_addr: got %b/%h want 1/%h", imem_req, imem_addr, exp_pc); end
            if (sb.size() > 0) begin
                n_tests++; if ({inst_pc, inst_data} !== sb[0]) begin n_fail++; $display("FAIL wrap_head: got %h_%h want %h", inst_pc, inst_data, sb[0]); end
                void'(sb.pop_front());
            end
            ack_fetch(1'b1);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_tests++; if (inst_pc !== 32'h4) begin n_fail++; $display("FAIL wrap_last: got %h want 00000004", inst_pc); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            ack_fetch(1'b0);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_tests++; if (occupancy !== CW'(3)) begin n_fail++; $display("FAIL midrst_pre: got %0d want 3", occupancy); end
        rst = 1'b0;
        #1;
        n_tests++; if ({imem_req, inst_valid, occupancy} !== {2'b00, CW'(0)}) begin n_fail++; $display("FAIL midrst_ctrl: got %b/%b/%0d want 0/0/0", imem_req, inst_valid, occupancy); end
        n_tests++; if ({imem_addr, inst_pc, inst_data} !== {RESET_PC, 64'h0}) begin n_fail++; $display("FAIL midrst_data: got %h/%h/%h want %h/0/0", imem_addr, inst_pc, inst_data, RESET_PC); end
        step();
        rst = 1'b1;
        sb.delete();
        exp_pc = RESET_PC;
        step();
        n_tests++; if ({imem_req, imem_addr} !== {1'b1, RESET_PC}) begin n_fail++; $display("FAIL midrst_restart: got %b/%h want 1/%h", imem_req, imem_addr, RESET_PC); end
        ack_fetch(1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        n_tests++; if (inst_valid !== 1'b1 || {inst_pc, inst_data} !== sb[0]) begin n_fail++; $display("FAIL midrst_entry: got %b %h_%h want %h", inst_valid, inst_pc, inst_data, sb[0]); end
    endtask

    task automatic test_back_to_back();
        logic ack;
        logic ready;
        do_reset();
        for (int i = 0; i < 120; i++) begin
            n_tests++; if (occupancy !== CW'(sb.size())) begin n_fail++; $display("FAIL b2b_occ: got %0d want %0d", occupancy, sb.size()); end
            n_tests++; if (inst_valid !== (sb.size() != 0)) begin n_fail++; $display("FAIL b2b_valid: got %b want %b", inst_valid, sb.size() != 0); end
            if (sb.size() > 0) begin
                n_tests++; if ({inst_pc, inst_data} !== sb[0]) begin n_fail++; $display("FAIL b2b_head: got %h_%h want %h", inst_pc, inst_data, sb[0]); end
            end
            if (sb.size() == DEPTH) begin
                n_tests++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL b2b_full_req: got %b want 0", imem_req); end
            end
            if (imem_req === 1'b1) begin
                n_tests++; if (imem_addr !== exp_pc) begin n_fail++; $display("FAIL b2b_addr: got %h want %h", imem_addr, exp_pc); end
            end
            ack   = (imem_req === 1'b1) && ($urandom_range(0, 2) != 0);
            ready = ($urandom_range(0, 1) == 1);
            if (ready && sb.size() > 0) void'(sb.pop_front());
            if (ack) ack_fetch(ready);
            else drive(1'b0, 32'h0, ready, 1'b0, 32'h0);
            step();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        exp_pc = RESET_PC;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        test_reset();
        test_stream();
        test_full();
        test_delayed_ack();
        test_redirect_drain();
        test_redirect_collide();
        test_wrap();
        test_reset_midstream();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
